// File: rtl/rr_packet_arbiter_if.sv
// Bundle of N packet-source channels and the single shared output channel.
// The arbiter uses the slave side; the environment driving sources and sink uses master.
interface rr_packet_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   io_in_valid;
    logic [N*W-1:0] io_in_bits;
    logic [N-1:0]   io_in_last;
    logic [N-1:0]   io_in_ready;
    logic           io_out_ready;
    logic           io_out_valid;
    logic [W-1:0]   io_out_bits;
    logic           io_out_last;
    logic [IW-1:0]  io_chosen;
    logic           io_locked;
    logic           io_err_overlong;

    modport slave (
        input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_last,
               io_chosen, io_locked, io_err_overlong
    );

    modport master (
        output io_in_valid, io_in_bits, io_in_last, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_last,
               io_chosen, io_locked, io_err_overlong
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: holds the grant for a whole multi-beat packet and
// forcibly ends any packet that reaches MAX_BEATS beats without a last flag.
module rr_packet_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_packet_arbiter_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        st;
    logic [IW-1:0] ptr;
    logic [IW-1:0] lock_idx;
    logic [CW-1:0] beats;
    logic          err;

    logic [IW-1:0] rr_idx;
    logic          found;
    logic [IW-1:0] chosen;
    logic          sel_valid;
    logic          sel_last;
    logic          fire;
    logic          force_rel;
    logic          out_last;

    // Rotating search starting just after ptr; with nothing valid it settles on ptr+1.
    always_comb begin
        rr_idx = IW'((32'(ptr) + 32'd1) % N);
        found  = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!found && bus.io_in_valid[IW'((32'(ptr) + k) % N)]) begin
                rr_idx = IW'((32'(ptr) + k) % N);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        chosen    = (st == LOCKED) ? lock_idx : rr_idx;
        sel_valid = (st == LOCKED) ? bus.io_in_valid[lock_idx] : (|bus.io_in_valid);
        sel_last  = bus.io_in_last[chosen];
        fire      = sel_valid && bus.io_out_ready;
        force_rel = fire && (beats == CW'(MAX_BEATS - 1)) && !sel_last;
        out_last  = sel_last || force_rel;
    end

    always_comb begin
        bus.io_chosen       = chosen;
        bus.io_out_valid    = sel_valid;
        bus.io_out_bits     = bus.io_in_bits[32'(chosen) * W +: W];
        bus.io_out_last     = out_last;
        bus.io_in_ready     = bus.io_out_ready ? (N'(1) << chosen) : '0;
        bus.io_locked       = (st == LOCKED);
        bus.io_err_overlong = err;
    end

    // Only a fire moves state; ptr advances solely when a packet completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
            beats    <= '0;
            err      <= 1'b0;
        end else begin
            err <= force_rel;
            if (fire) begin
                case (st)
                    IDLE: begin
                        if (out_last) begin
                            ptr <= chosen;
                        end else begin
                            st       <= LOCKED;
                            lock_idx <= chosen;
                            beats    <= CW'(1);
                        end
                    end
                    LOCKED: begin
                        if (out_last) begin
                            st    <= IDLE;
                            ptr   <= lock_idx;
                            beats <= '0;
                        end else begin
                            beats <= beats + CW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: directed scenarios with literal expectations plus
// a randomized run, all outputs compared every cycle against a packet-level model.
module tb_rr_packet_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned MAX = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    rr_packet_arbiter_if #(.N(N), .W(W)) bus ();

    rr_packet_arbiter #(.N(N), .W(W), .MAX_BEATS(MAX)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner = source holding the channel (-1 none), last = last source to finish a packet.
    int m_owner = -1;
    int m_last  = 0;
    int m_len   = 0;
    int m_err   = 0;
    int n_owner, n_last, n_len, n_err;
    bit have_next = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - last - 1 + 2 * N) % N;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return (best < 0) ? (last + 1) % N : best;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_locked", 32'(bus.io_locked), 0);
            chk("rst_err", 32'(bus.io_err_overlong), 0);
        end else begin
            int   c;
            logic v, l, f, wd;
            c  = (m_owner < 0) ? rr_pick(bus.io_in_valid, m_last) : m_owner;
            v  = (m_owner < 0) ? (bus.io_in_valid != '0) : bus.io_in_valid[c];
            f  = v && bus.io_out_ready;
            wd = f && (m_len == MAX - 1) && !bus.io_in_last[c];
            l  = bus.io_in_last[c] || wd;
            chk("m_chosen", 32'(bus.io_chosen), 32'(c));
            chk("m_valid", 32'(bus.io_out_valid), 32'(v));
            chk("m_ready", 32'(bus.io_in_ready), bus.io_out_ready ? (32'd1 << c) : 32'd0);
            chk("m_bits", 32'(bus.io_out_bits), 32'(bus.io_in_bits[c*W +: W]));
            chk("m_last", 32'(bus.io_out_last), 32'(l));
            chk("m_locked", 32'(bus.io_locked), 32'(m_owner >= 0));
            chk("m_err", 32'(bus.io_err_overlong), 32'(m_err));
            n_owner = m_owner;
            n_last  = m_last;
            n_len   = m_len;
            n_err   = wd ? 1 : 0;
            if (f) begin
                if (l) begin
                    n_owner = -1;
                    n_last  = c;
                    n_len   = 0;
                end else begin
                    n_owner = c;
                    n_len   = m_len + 1;
                end
            end
            have_next = 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner   <= -1;
            m_last    <= 0;
            m_len     <= 0;
            m_err     <= 0;
            have_next <= 0;
        end else if (have_next) begin
            m_owner   <= n_owner;
            m_last    <= n_last;
            m_len     <= n_len;
            m_err     <= n_err;
            have_next <= 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bits(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        bus.io_in_bits = {b3, b2, b1, b0};
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 0, 1};
        bus.io_in_valid  = '0;
        bus.io_in_bits   = '0;
        bus.io_in_last   = '0;
        bus.io_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();

        // Single-beat fairness
        bus.io_in_valid  = 4'hF;
        bus.io_in_last   = 4'hF;
        bus.io_out_ready = 1'b1;
        set_bits(8'h10, 8'h11, 8'h12, 8'h13);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t1_chosen", 32'(bus.io_chosen), 32'(seq[k]));
            chk("t1_ready", 32'(bus.io_in_ready), 32'd1 << seq[k]);
            next_cycle();
        end
        bus.io_in_valid = '0;
        next_cycle();

        // Packet lock: in0 three beats, in1 waiting with a single beat
        bus.io_in_valid = 4'b0011;
        bus.io_in_last  = 4'b0010;
        set_bits(8'hA0, 8'hB0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t2_first", 32'(bus.io_out_bits), 32'hA0);
        chk("t2_unlocked", 32'(bus.io_locked), 0);
        next_cycle();
        set_bits(8'hA1, 8'hB0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t2_locked", 32'(bus.io_locked), 1);
        chk("t2_a1", 32'(bus.io_out_bits), 32'hA1);
        chk("t2_ready", 32'(bus.io_in_ready), 32'b0001);
        next_cycle();
        set_bits(8'hA2, 8'hB0, 8'h00, 8'h00);
        bus.io_in_last = 4'b0011;
        @(negedge clk);
        chk("t2_a2", 32'(bus.io_out_bits), 32'hA2);
        chk("t2_a2_last", 32'(bus.io_out_last), 1);
        next_cycle();
        bus.io_in_valid = 4'b0010;
        @(negedge clk);
        chk("t2_b0_chosen", 32'(bus.io_chosen), 1);
        chk("t2_b0_bits", 32'(bus.io_out_bits), 32'hB0);
        chk("t2_b0_unlocked", 32'(bus.io_locked), 0);
        next_cycle();
        bus.io_in_valid = '0;
        next_cycle();

        // Stall inside a lock on in2 with in1 knocking
        bus.io_in_valid = 4'b0100;
        bus.io_in_last  = 4'b0000;
        set_bits(8'h00, 8'h5A, 8'hC0, 8'h00);
        next_cycle();
        bus.io_in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(bus.io_out_valid), 0);
            chk("t3_stall_chosen", 32'(bus.io_chosen), 2);
            chk("t3_stall_ready", 32'(bus.io_in_ready), 32'b0100);
            next_cycle();
        end
        bus.io_in_valid = 4'b0110;
        bus.io_in_last  = 4'b0100;
        set_bits(8'h00, 8'h5A, 8'hC1, 8'h00);
        @(negedge clk);
        chk("t3_resume_bits", 32'(bus.io_out_bits), 32'hC1);
        chk("t3_resume_valid", 32'(bus.io_out_valid), 1);
        next_cycle();
        bus.io_in_valid = '0;
        next_cycle();

        // Backpressure: nothing moves while the sink is not ready
        bus.io_out_ready = 1'b0;
        bus.io_in_valid  = 4'b1000;
        bus.io_in_last   = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_ready", 32'(bus.io_in_ready), 0);
            chk("t4_locked", 32'(bus.io_locked), 0);
            chk("t4_chosen", 32'(bus.io_chosen), 3);
            next_cycle();
        end
        bus.io_out_ready = 1'b1;
        bus.io_in_valid  = 4'hF;
        bus.io_in_last   = 4'hF;
        @(negedge clk);
        chk("t4_ptr_kept", 32'(bus.io_chosen), 3);
        next_cycle();
        bus.io_in_valid = '0;
        next_cycle();

        // Watchdog: in1 never sets last, in2 waits with a single beat
        bus.io_in_valid = 4'b0110;
        bus.io_in_last  = 4'b0100;
        for (int b = 1; b <= 16; b++) begin
            set_bits(8'h00, 8'(b), 8'hE2, 8'h00);
            @(negedge clk);
            chk("t5_chosen", 32'(bus.io_chosen), 1);
            chk("t5_last", 32'(bus.io_out_last), (b == 16) ? 1 : 0);
            chk("t5_err_low", 32'(bus.io_err_overlong), 0);
            next_cycle();
        end
        @(negedge clk);
        chk("t5_err_pulse", 32'(bus.io_err_overlong), 1);
        chk("t5_released", 32'(bus.io_locked), 0);
        chk("t5_in2_next", 32'(bus.io_chosen), 2);
        next_cycle();
        @(negedge clk);
        chk("t5_err_gone", 32'(bus.io_err_overlong), 0);
        chk("t5_in1_again", 32'(bus.io_chosen), 1);
        next_cycle();
        bus.io_in_valid = 4'b0010;
        bus.io_in_last  = 4'b0000;
        repeat (3) next_cycle();
        bus.io_in_last = 4'b0010;
        next_cycle();
        bus.io_in_valid = '0;
        next_cycle();

        // Asynchronous reset during the second beat of an in3 packet
        bus.io_in_valid = 4'b1000;
        bus.io_in_last  = 4'b0000;
        next_cycle();
        chk("t6_locked_before", 32'(bus.io_locked), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_locked_drop", 32'(bus.io_locked), 0);
        chk("t6_err_rst", 32'(bus.io_err_overlong), 0);
        bus.io_in_valid = 4'hF;
        bus.io_in_last  = 4'hF;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", 32'(bus.io_chosen), 1);
        chk("t6_err", 32'(bus.io_err_overlong), 0);
        next_cycle();

        // Randomized traffic with phases biased towards short, long and runaway packets
        for (int c = 0; c < 3000; c++) begin
            int lim;
            lim = (c < 1000) ? 2 : ((c < 2000) ? 8 : 40);
            bus.io_in_valid  = (c >= 2000) ? (4'($urandom) | 4'($urandom)) : 4'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.io_in_last[i]       = ($urandom_range(0, lim - 1) == 0);
                bus.io_in_bits[i*W +: W] = W'($urandom);
            end
            bus.io_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin arbiter for multi-beat packets over the shared decoupled 8-bit output channel.
- Same fairness rule as the single-beat round-robin arbiter. Once a multi-beat packet's first beat is accepted, the grant is held until that packet's last beat transfers, so beats from different sources never interleave.
- Includes a beat-limit watchdog that forcibly releases a runaway packet.
- Sits between N packet sources and one downstream queue/link.

Parameters:
- N, 4, number of requesters (≥2); index width IW = clog2(N).
- W, 8, payload width in bits.
- MAX_BEATS, 16, maximum beats per packet (≥2); counter width CW = clog2(MAX_BEATS+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  N  per-requester beat valid.
- io_in_bits  in  N*W  per-requester payload; slice i = bits[i*W +: W].
- io_in_last  in  N  per-requester last-beat flag.
- io_in_ready  out  N  per-requester ready.
- io_out_ready  in  1  downstream ready.
- io_out_valid  out  1  output beat valid.
- io_out_bits  out  W  muxed payload.
- io_out_last  out  1  muxed last flag; also forced high on the watchdog beat.
- io_chosen  out  IW  selected requester index.
- io_locked  out  1  high while in LOCKED state.
- io_err_overlong  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Fire = io_out_valid && io_out_ready. All outputs are combinational from registers and inputs (zero latency), except io_err_overlong, which is registered.
- State registers:
  - st ∈ {IDLE, LOCKED}, reset IDLE.
  - ptr (IW), last-granted index, reset 0.
  - lock_idx (IW), reset 0.
  - beats (CW), beats accepted in the current packet, reset 0.
  - err, reset 0.
- IDLE selection (io_chosen), round-robin:
  - Pick the lowest index i > ptr with valid[i].
  - If none, pick the lowest index with valid[i].
  - If no input is valid, io_chosen = the lowest index i > ptr (wrapping to 0); this value is don't-care but must be deterministic.
  - io_out_valid = OR of io_in_valid.
  - io_in_ready[i] = io_out_ready && (i == io_chosen). Exactly one ready may be high.
- LOCKED: io_chosen = lock_idx; io_out_valid = io_in_valid[lock_idx]; io_in_ready[i] = io_out_ready && (i == lock_idx). All other inputs are ignored even if valid.
- io_out_bits and io_in_last are muxed by io_chosen.
- force = fire && (beats == MAX_BEATS-1) && !io_in_last[io_chosen].
- io_out_last = io_in_last[io_chosen] || force.
- Transitions on fire:
  - IDLE, io_out_last=0 → LOCKED; lock_idx ← io_chosen; beats ← 1.
  - IDLE, io_out_last=1 (single-beat packet) → stay IDLE; ptr ← io_chosen; beats stays 0.
  - LOCKED, io_out_last=0 → beats ← beats+1.
  - LOCKED, io_out_last=1 → IDLE; ptr ← lock_idx; beats ← 0.
- No fire: all state holds. This includes when the locked source deasserts valid mid-packet: the lock is kept and the output stalls.
- Watchdog:
  - The watchdog beat is the MAX_BEATS-th beat of a packet.
  - On a force fire, err ← 1 for exactly the next cycle, then returns to 0.
  - The source's remaining beats are treated as a new packet and arbitrated normally.
  - io_err_overlong = err.
- ptr only ever updates on a last-beat fire. A non-last first beat does not move it.
- Reset assertion at any time returns all state to its reset value immediately (asynchronously). An in-flight packet is abandoned; no error pulse is produced.
- io_in_valid, io_in_bits and io_in_last are sampled only via the fire condition. The block never produces X on io_out_* when the inputs are known.

Test Plan:
1. Single-beat fairness. After reset, hold all 4 valid with last=1 and io_out_ready=1 → io_chosen sequence is 1,2,3,0,1; each io_in_ready is one-hot and matches io_chosen.
2. Packet lock.
   - Stimulus: in0 sends a 3-beat packet (0xA0, 0xA1, 0xA2, last on the third beat) while in1 holds valid with 0xB0.
   - Required response: io_locked=1 after the first beat; io_out_bits = A0, A1, A2 with no B0 interleaved; B0 is granted on the following cycle; ptr = 0 before the B0 grant.
3. Stall inside a lock.
   - Stimulus: during an in2 packet, drop io_in_valid[2] for 3 cycles while in1 is valid.
   - Required response: io_out_valid=0, io_chosen=2, io_in_ready[1]=0 throughout; the packet resumes when in2 reasserts valid.
4. Backpressure. Hold io_out_ready=0 with in3 valid for 5 cycles → all io_in_ready=0; no state change (io_locked=0, beats=0, ptr unchanged).
5. Watchdog.
   - Stimulus: with MAX_BEATS=16, in1 streams 20 beats with last=0.
   - Required response: io_out_last=1 on beat 16; io_err_overlong is high for exactly the one cycle after that beat; lock released; with in2 valid, in2 is granted next.
6. Async reset mid-packet. Assert reset (low) mid-cycle on the 2nd beat of a 4-beat packet → io_locked drops immediately; after release, the first grant among all-valid inputs is index 1; io_err_overlong=0.
